// File: rtl/ide_pio_sequencer.sv
// IDE PIO cycle sequencer: turns a qualified 68k access into ATA-timed
// setup / strobe / recovery phases, stretches the strobe on IORDY and
// returns a registered DTACK to the bus glue.
module ide_pio_sequencer #(
    parameter int unsigned SLOW_SETUP   = 1,
    parameter int unsigned SLOW_ACTIVE  = 3,
    parameter int unsigned SLOW_RECOVER = 2,
    parameter int unsigned FAST_SETUP   = 1,
    parameter int unsigned FAST_ACTIVE  = 1,
    parameter int unsigned FAST_RECOVER = 1,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic CLK,
    input  logic RESET,
    input  logic ide_access,
    input  logic ide_enabled,
    input  logic AS_n,
    input  logic UDS_n,
    input  logic LDS_n,
    input  logic RW,
    input  logic IORDY,
    input  logic pio_fast,
    input  logic err_clr,
    output logic IOR_n,
    output logic IOW_n,
    output logic DTACK,
    output logic busy,
    output logic timeout_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RECOVER
    } state_t;

    // Terminal phase-counter values (count runs 0 .. N-1 within a phase)
    localparam logic [3:0] SLOW_SETUP_LAST   = 4'(SLOW_SETUP - 1);
    localparam logic [3:0] SLOW_ACTIVE_LAST  = 4'(SLOW_ACTIVE - 1);
    localparam logic [3:0] SLOW_RECOVER_LAST = 4'(SLOW_RECOVER - 1);
    localparam logic [3:0] FAST_SETUP_LAST   = 4'(FAST_SETUP - 1);
    localparam logic [3:0] FAST_ACTIVE_LAST  = 4'(FAST_ACTIVE - 1);
    localparam logic [3:0] FAST_RECOVER_LAST = 4'(FAST_RECOVER - 1);
    localparam logic [7:0] TIMEOUT_VAL       = 8'(TIMEOUT);

    state_t     state_q, state_d;
    logic [3:0] phase_q, phase_d;
    logic [7:0] wait_q, wait_d;
    logic       rw_q, rw_d;
    logic       fast_q, fast_d;
    logic       err_q, err_d;
    logic       ior_n_q, ior_n_d;
    logic       iow_n_q, iow_n_d;
    logic       dtack_q, dtack_d;

    logic       start;
    logic [3:0] setup_last, active_last, recover_last;

    assign start        = ide_enabled & ide_access & ~AS_n & (~UDS_n | ~LDS_n);
    assign setup_last   = fast_q ? FAST_SETUP_LAST   : SLOW_SETUP_LAST;
    assign active_last  = fast_q ? FAST_ACTIVE_LAST  : SLOW_ACTIVE_LAST;
    assign recover_last = fast_q ? FAST_RECOVER_LAST : SLOW_RECOVER_LAST;

    // Next-state, counters and registered strobe/DTACK values
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        wait_d  = wait_q;
        rw_d    = rw_q;
        fast_d  = fast_q;
        err_d   = err_q;

        if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETUP;
                    phase_d = '0;
                    wait_d  = '0;
                    rw_d    = RW;
                    fast_d  = pio_fast;
                end
            end
            ST_SETUP: begin
                if (AS_n) begin
                    state_d = ST_IDLE;
                end else if (phase_q == setup_last) begin
                    state_d = ST_STROBE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            ST_STROBE: begin
                // Abort beats both IORDY completion and timeout
                if (AS_n) begin
                    state_d = ST_RECOVER;
                    phase_d = '0;
                end else if (phase_q != active_last) begin
                    phase_d = phase_q + 4'd1;
                end else if (IORDY) begin
                    state_d = ST_HOLD;
                end else if (wait_q == TIMEOUT_VAL) begin
                    state_d = ST_HOLD;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_HOLD: begin
                if (AS_n) begin
                    state_d = ST_RECOVER;
                    phase_d = '0;
                end
            end
            ST_RECOVER: begin
                if (phase_q == recover_last) begin
                    state_d = ST_IDLE;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they are clean flops
        ior_n_d = ~((state_d == ST_STROBE) &  rw_d);
        iow_n_d = ~((state_d == ST_STROBE) & ~rw_d);
        dtack_d = (state_d == ST_HOLD);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            wait_q  <= '0;
            rw_q    <= 1'b1;
            fast_q  <= 1'b0;
            err_q   <= 1'b0;
            ior_n_q <= 1'b1;
            iow_n_q <= 1'b1;
            dtack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            wait_q  <= wait_d;
            rw_q    <= rw_d;
            fast_q  <= fast_d;
            err_q   <= err_d;
            ior_n_q <= ior_n_d;
            iow_n_q <= iow_n_d;
            dtack_q <= dtack_d;
        end
    end

    assign IOR_n       = ior_n_q;
    assign IOW_n       = iow_n_q;
    assign DTACK       = dtack_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = err_q;

endmodule
